// File: rtl/cmp_share_pkg.sv
// Shared types for the arbitrated set-compare unit: opcode enum, widths and request struct.
package cmp_share_pkg;

    localparam int CMP_OP_W   = 3;
    localparam int CMP_DATA_W = 32;

    typedef enum logic [CMP_OP_W-1:0] {
        CMP_EQ  = 3'd0,
        CMP_NEQ = 3'd1,
        CMP_LT  = 3'd2,
        CMP_LEZ = 3'd3,
        CMP_LTZ = 3'd4,
        CMP_GTZ = 3'd5
    } cmp_op_e;

    // op is kept as raw bits so the illegal codes 6-7 travel through unchanged.
    typedef struct packed {
        logic [CMP_OP_W-1:0]   op;
        logic [CMP_DATA_W-1:0] a;
        logic [CMP_DATA_W-1:0] b;
        logic                  sign;
    } cmp_req_t;

endpackage

// File: rtl/cmp_unit.sv
// Combinational set-compare: produces a 0/1 result with S/Z/V/N flags and an illegal-op flag.
module cmp_unit
    import cmp_share_pkg::*;
#(
    parameter int DATA_W = CMP_DATA_W
) (
    input  logic [CMP_OP_W-1:0] op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                sign,
    output logic [DATA_W-1:0]   s,
    output logic                z,
    output logic                v,
    output logic                n,
    output logic                err
);

    logic r;

    always_comb begin
        r   = 1'b0;
        err = 1'b0;
        case (op)
            CMP_EQ:  r = (a == b);
            CMP_NEQ: r = (a != b);
            CMP_LT:  r = sign ? ($signed(a) < $signed(b)) : (a < b);
            // Zero compares are always signed and ignore b.
            CMP_LEZ: r = a[DATA_W-1] || (a == '0);
            CMP_LTZ: r = a[DATA_W-1];
            CMP_GTZ: r = !a[DATA_W-1] && (a != '0);
            default: err = 1'b1;
        endcase
    end

    assign s = {{(DATA_W-1){1'b0}}, r};
    assign z = ~r;
    assign v = 1'b0;
    assign n = 1'b0;

endmodule

// File: rtl/cmp_share_arb.sv
// Two-port round-robin front end for one shared cmp_unit with a one-entry response slot.
// Optional per-port saturating grant counters are built when CMP_GRANT_CNT_EN is defined.
module cmp_share_arb
    import cmp_share_pkg::*;
#(
    parameter int DATA_W = CMP_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][CMP_OP_W-1:0]   req_op,
    input  logic [1:0][DATA_W-1:0]     req_a,
    input  logic [1:0][DATA_W-1:0]     req_b,
    input  logic [1:0]                 req_sign,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic [DATA_W-1:0]          rsp_s,
    output logic                       rsp_z,
    output logic                       rsp_v,
    output logic                       rsp_n,
    output logic                       rsp_err,
    output logic [CNT_W-1:0]           grant_cnt0,
    output logic [CNT_W-1:0]           grant_cnt1
);

    // Handshake: a transfer happens on a port when valid & ready at the rising edge.
    // Ready goes to at most one port, only when the slot is free; a loser holds its
    // request. The response slot transfers on rsp_valid & rsp_ready and holds otherwise.
    logic        rr_ptr;
    logic        slot_free;
    logic        grant;
    logic        winner;
    cmp_req_t    win;
    logic [DATA_W-1:0] u_s;
    logic        u_z, u_v, u_n, u_err;

    always_comb begin
        slot_free = !rsp_valid || rsp_ready;
        winner    = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
        grant     = rst_n && slot_free && (req_valid != 2'b00);
        req_ready = 2'b00;
        if (grant) req_ready[winner] = 1'b1;
        win.op    = req_op[winner];
        win.a     = req_a[winner];
        win.b     = req_b[winner];
        win.sign  = req_sign[winner];
    end

    cmp_unit #(.DATA_W(DATA_W)) u_cmp (
        .op   (win.op),
        .a    (win.a),
        .b    (win.b),
        .sign (win.sign),
        .s    (u_s),
        .z    (u_z),
        .v    (u_v),
        .n    (u_n),
        .err  (u_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_s     <= '0;
            rsp_z     <= 1'b1;
            rsp_v     <= 1'b0;
            rsp_n     <= 1'b0;
            rsp_err   <= 1'b0;
            rr_ptr    <= 1'b0;
        end else if (grant) begin
            // A grant refills the slot even while it drains, keeping rsp_valid high.
            rsp_valid <= 1'b1;
            rsp_id    <= winner;
            rsp_s     <= u_s;
            rsp_z     <= u_z;
            rsp_v     <= u_v;
            rsp_n     <= u_n;
            rsp_err   <= u_err;
            rr_ptr    <= ~winner;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef CMP_GRANT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (grant) begin
            if (!winner && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
            if (winner && grant_cnt1 != '1)  grant_cnt1 <= grant_cnt1 + 1'b1;
        end
    end
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_cmp_share_arb.sv
// Directed bench for cmp_share_arb: response scoreboard plus direct handshake/reset checks.
module tb_cmp_share_arb;
    import cmp_share_pkg::*;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int EW = DW + 3;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][2:0]   req_op;
    logic [1:0][DW-1:0] req_a;
    logic [1:0][DW-1:0] req_b;
    logic [1:0]        req_sign;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DW-1:0]     rsp_s;
    logic              rsp_z, rsp_v, rsp_n, rsp_err;
    logic [CW-1:0]     grant_cnt0, grant_cnt1;

    logic [EW-1:0]     exp_q[$];
    logic [EW-1:0]     exp_e;
    int                n_checks = 0;
    int                n_pass   = 0;

    cmp_share_arb #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sign   (req_sign),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_s      (rsp_s),
        .rsp_z      (rsp_z),
        .rsp_v      (rsp_v),
        .rsp_n      (rsp_n),
        .rsp_err    (rsp_err),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [EW-1:0] mk(input logic id, input logic err, input logic z,
                                         input logic [DW-1:0] s);
        return {id, err, z, s};
    endfunction

    // Driver tasks
    task automatic set_req(input int p, input logic [2:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic sg);
        req_op[p]    = op;
        req_a[p]     = a;
        req_b[p]     = b;
        req_sign[p]  = sg;
        req_valid[p] = 1'b1;
    endtask

    task automatic clr_req(input int p);
        req_valid[p] = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted response must match the head of exp_q
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_rsp", 64'd1, 64'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("sb_rsp", {rsp_id, rsp_err, rsp_z, rsp_s}, exp_e);
                check("sb_vn", {rsp_v, rsp_n}, 64'd0);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_sign  = 2'b00;
        rsp_ready = 1'b1;

        // Reset state, with a request pending to show ready is held low
        set_req(0, 3'(CMP_NEQ), 32'd5, 32'd7, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 2'b00);
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_s", rsp_s, 32'd0);
        check("rst_z", rsp_z, 1'b1);
        check("rst_vn_id_err", {rsp_v, rsp_n, rsp_id, rsp_err}, 4'b0000);
        check("rst_cnt", {grant_cnt0, grant_cnt1}, 8'd0);
        clr_req(0);
        rst_n = 1'b1;

        // Fairness: both ports valid, ids must alternate 0,1,0,1
        set_req(0, 3'(CMP_EQ), 32'd3, 32'd3, 1'b0);
        set_req(1, 3'(CMP_LT), 32'hFFFF_FFFF, 32'd1, 1'b1);
        #1;
        check("rr_first_ready", req_ready, 2'b01);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'd1));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'd1));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'd1));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'd1));
        repeat (4) cycle();

        // Unsigned LT: 0xFFFFFFFF < 1 is false
        clr_req(0);
        set_req(1, 3'(CMP_LT), 32'hFFFF_FFFF, 32'd1, 1'b0);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'd0));
        cycle();
        clr_req(1);

        // Single NEQ, one-cycle latency
        set_req(0, 3'(CMP_NEQ), 32'd5, 32'd7, 1'b0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'd1));
        cycle();
        check("neq_valid", rsp_valid, 1'b1);
        check("neq_id", rsp_id, 1'b0);
        check("neq_s", rsp_s, 32'd1);
        check("neq_zvn", {rsp_z, rsp_v, rsp_n}, 3'b000);
        clr_req(0);
        cycle();
        check("idle_valid", rsp_valid, 1'b0);

        // Stall: slot full, rsp_ready low; rr_ptr is 1 here so port 1 wins first
        rsp_ready = 1'b0;
        set_req(0, 3'(CMP_EQ), 32'd3, 32'd3, 1'b0);
        set_req(1, 3'(CMP_LEZ), 32'd0, 32'd9, 1'b0);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'd1));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'd1));
        cycle();
        check("stall_ready0", req_ready, 2'b00);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_ready", req_ready, 2'b00);
            check("stall_hold", {rsp_valid, rsp_id, rsp_s}, {1'b1, 1'b1, 32'd1});
        end
        rsp_ready = 1'b1;
        #1;
        check("refill_ready", req_ready, 2'b01);
        cycle();
        check("refill_valid", rsp_valid, 1'b1);
        check("refill_id", rsp_id, 1'b0);
        clr_req(0);
        clr_req(1);
        cycle();

        // Zero compares and illegal opcode, back to back from port 0
        set_req(0, 3'(CMP_GTZ), 32'h8000_0000, 32'd0, 1'b0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 32'd0));
        cycle();
        set_req(0, 3'd7, 32'd1, 32'd1, 1'b0);
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 32'd0));
        cycle();
        check("illegal_err", {rsp_err, rsp_s}, {1'b1, 32'd0});
        set_req(0, 3'(CMP_LTZ), 32'hFFFF_FFFF, 32'd0, 1'b0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'd1));
        cycle();
        set_req(0, 3'(CMP_EQ), 32'd3, 32'd4, 1'b0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 32'd0));
        cycle();
        clr_req(0);
        cycle();

        // Async reset during a stalled response; rr_ptr is 1 before reset
        rsp_ready = 1'b0;
        set_req(0, 3'(CMP_EQ), 32'd1, 32'd1, 1'b0);
        cycle();
        check("pre_rst_valid", rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", rsp_valid, 1'b0);
        check("async_rst_ready", req_ready, 2'b00);
        clr_req(0);
        cycle();
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        set_req(0, 3'(CMP_EQ), 32'd2, 32'd2, 1'b0);
        set_req(1, 3'(CMP_EQ), 32'd2, 32'd3, 1'b0);
        #1;
        check("post_rst_rr", req_ready, 2'b01);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'd1));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'd0));
        cycle();
        clr_req(0);
        cycle();
        clr_req(1);
        cycle();
        cycle();

        // Grant counters: 20 port-1 grants after a fresh reset
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        set_req(1, 3'(CMP_EQ), 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 20; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'd1));
        repeat (20) cycle();
        clr_req(1);
        cycle();
        cycle();
`ifdef CMP_GRANT_CNT_EN
        check("cnt1_sat", grant_cnt1, 4'd15);
`else
        check("cnt1_off", grant_cnt1, 4'd0);
`endif
        check("cnt0", grant_cnt0, 4'd0);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cmp_share_arb.md
# cmp_share_arb

Shares one set-compare unit (EQ/NEQ/LT/LEZ/LTZ/GTZ, S/Z/V/N flag convention of the ALU compare modules) between two requesters: the branch resolver (port 0) and the execute stage (port 1). Round-robin arbitration, valid/ready handshakes on both request ports, and a one-entry registered response slot tagged with the winner's ID. Sits beside the ALU in the execute stage, so a second comparator is not needed for branch resolution.

## Interface
- DATA_W, 32, operand width
- CNT_W, 16, grant counter width (used only with CMP_GRANT_CNT_EN)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port accept; transfer when valid & ready
- req_op  in  2x3  per-port opcode (package enum)
- req_a, req_b  in  2xDATA_W  per-port operands
- req_sign  in  2  per-port signed select (LT only)
- rsp_valid  out  1  response slot full
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  port that issued the response
- rsp_s  out  DATA_W  result, 0 or 1
- rsp_z, rsp_v, rsp_n  out  1  flags
- rsp_err  out  1  illegal opcode was issued
- grant_cnt0, grant_cnt1  out  CNT_W  grants per port (zero without macro)

## Operation
- Opcodes: 0 EQ (A==B), 1 NEQ (A!=B), 2 LT (A<B; signed if sign=1, else unsigned), 3 LEZ, 4 LTZ, 5 GTZ (these three compare A against 0, always signed, B ignored). Codes 6–7 are illegal: S=0, err=1.
- Flags: S[0]=result, S[DATA_W-1:1]=0; Z = (S==0); V=0; N=0.
- Slot free when !rsp_valid or (rsp_valid & rsp_ready).
- Arbitration: if the slot is free, grant one valid port. If only one port is valid, it wins. If both are valid, port rr_ptr wins. At most one grant per cycle.
- req_ready[i] = slot free & grant[i]. This is combinational from req_valid, rr_ptr, rsp_valid and rsp_ready. A losing port sees ready=0 and must hold its request stable.
- On grant: register the compare result, flags, err and id into the slot; set rsp_valid; rr_ptr <= ~winner.
- With no grant, rr_ptr holds.
- Response handshake: rsp_valid & rsp_ready drops the slot unless a new grant refills it in the same cycle. A refill keeps rsp_valid high.
- Response outputs stay stable while rsp_valid & !rsp_ready.

## Timing
- Latency: grant in cycle N, response visible in cycle N+1.
- Throughput: 1 response/cycle while rsp_ready=1.
- Fairness: two continuously valid ports alternate 0,1,0,1… once rr_ptr=0 after reset.
- Reset (asynchronous, any time, including mid-transfer):
  - rsp_valid=0, rsp_s=0, rsp_z=1, rsp_v=0, rsp_n=0, rsp_id=0, rsp_err=0
  - rr_ptr=0; counters=0
  - req_ready is 0 while rst_n=0.
  - An in-flight response is discarded, not replayed.
- Stall with the slot full and rsp_ready=0: both req_ready=0, and rr_ptr is frozen.

## Configuration
- CMP_GRANT_CNT_EN defined: grant_cnt0/1 increment on each grant of their port. They saturate at all-ones and never wrap.
- CMP_GRANT_CNT_EN undefined: the counter registers are not built, and grant_cnt0/1 are tied to 0. Ports stay present.

## Structure
- Package cmp_share_pkg holds:
  - the cmp_op_e enum (CMP_EQ…CMP_GTZ)
  - the CMP_OP_W=3 constant
  - a cmp_req_t struct {op, a, b, sign}
- Sub-module cmp_unit: purely combinational (op, a, b, sign -> s, z, v, n, err). It is instantiated once, on the muxed winner's operands.
- Arbiter, slot and counters live in the top level.

## Test plan
- Reset, then port 0 NEQ a=5 b=7 with rsp_ready=1 -> next cycle rsp_valid=1, id=0, S=1, Z=0, V=0, N=0.
- Both ports valid continuously: port 0 EQ 3,3; port 1 LT signed a=0xFFFFFFFF b=1. Expect ids 0,1,0,1; port 0 S=1; port 1 S=1. With sign=0, port 1 S=0, Z=1.
- rsp_ready=0 for 3 cycles with the slot full -> req_ready=00, outputs held. rsp_ready=1 -> drain and refill in the same cycle, rsp_valid stays 1.
- LEZ a=0 -> S=1; GTZ a=0x80000000 -> S=0, Z=1; op=7 -> err=1, S=0.
- Assert rst_n low while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 immediately, and the first grant after release goes to port 0.
- With CMP_GRANT_CNT_EN and CNT_W=4: 20 port-1 grants -> grant_cnt1=15, grant_cnt0=0. Without the macro -> both read 0.
